iter_shifter: RTL and testbench

- Multicycle shift unit that consumes the 5-bit shift amount produced by the 4:1 5-bit shift-amount select mux.
- Shifts a 32-bit operand one bit position per clock; the result feeds the write-back mux toward the register bank.
- Operates under control-unit handshake: start pulse in, busy level and done pulse out.

---
 rtl/iter_shifter.sv | 104 ++++++++++
 tb/tb_iter_shifter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Multicycle shifter: one bit position per clock for SLL/SRL/SRA/ROR, with a
// start/busy/done handshake toward the control unit.
module iter_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpRor = 2'b11;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_count;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] w_shifted;
    logic             w_accept;

    assign w_accept = (r_state == StIdle) && start;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = (shamt != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                if (r_count == SHW'(1)) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            StShift: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Single-position shift of the working register per latched op
    always_comb begin
        w_shifted = r_data;
        unique case (r_op)
            OpSll:   w_shifted = {r_data[WIDTH-2:0], 1'b0};
            OpSrl:   w_shifted = {1'b0, r_data[WIDTH-1:1]};
            OpSra:   w_shifted = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            OpRor:   w_shifted = {r_data[0], r_data[WIDTH-1:1]};
            default: w_shifted = r_data;
        endcase
    end

    // Datapath: operand/count/op captured on accept, shifted while in StShift
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data  <= '0;
            r_count <= '0;
            r_op    <= OpSll;
        end else if (w_accept) begin
            r_data  <= data_in;
            r_count <= shamt;
            r_op    <= op;
        end else if (r_state == StShift) begin
            r_data  <= w_shifted;
            r_count <= r_count - SHW'(1);
        end
    end

    assign data_out = r_data;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed-vector bench for iter_shifter: latency, busy/done handshake,
// result values, ignored restarts and mid-operation reset.
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    iter_shifter #(
        .WIDTH(32),
        .SHW  (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .data_out(data_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Launches one operation and follows it to completion. poke_edge > 0 re-asserts
    // start with a different operand at that edge (counted from the accepting edge).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] sh, input logic [31:0] exp, input int poke_edge);
        int edges;
        int busy_cnt;
        int overlap;
        int extra;
        logic seen;
        edges    = 0;
        busy_cnt = 0;
        overlap  = 0;
        extra    = 0;
        seen     = 1'b0;
        #1;
        start   = 1'b1;
        op      = o;
        data_in = d;
        shamt   = sh;
        @(posedge clk);
        edges = 1;
        #1;
        start   = 1'b0;
        op      = ~o;
        data_in = ~d;
        shamt   = ~sh;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && done) overlap++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
            edges++;
            if (edges == poke_edge) begin
                #1;
                start   = 1'b1;
                data_in = 32'hFFFF_FFFF;
            end else if (start) begin
                #1;
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, "_edges"}, edges, 32'(sh) + 32'd1);
        check_eq({tag, "_busy_cycles"}, busy_cnt, 32'(sh));
        check_eq({tag, "_data"}, data_out, exp);
        // No second done pulse and no stray busy after completion
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || done) extra++;
            if (busy && done) overlap++;
        end
        check_eq({tag, "_after_idle"}, extra, 32'd0);
        check_eq({tag, "_hold"}, data_out, exp);
        check_eq({tag, "_overlap"}, overlap, 32'd0);
    endtask

    initial begin
        int stray;
        reset   = 1'b0;
        start   = 1'b1;
        op      = 2'b00;
        data_in = 32'hA5A5_A5A5;
        shamt   = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_data", data_out, 32'h0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        start = 1'b0;

        run_op("sll4",   2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010, 0);
        run_op("sra31",  2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 0);
        run_op("srl31",  2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 0);
        run_op("ror1",   2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 0);
        run_op("ror8",   2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, 0);
        run_op("sll0",   2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
        run_op("restart", 2'b01, 32'hF000_0000, 5'd10, 32'h003C_0000, 3);

        // Reset at edge 3 of an SLL by 20
        #1;
        start   = 1'b1;
        op      = 2'b00;
        data_in = 32'h0000_0003;
        shamt   = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_data", data_out, 32'h0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        #1 reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (busy || done) stray++;
        end
        check_eq("abort_no_done", stray, 32'd0);

        run_op("post_rst", 2'b00, 32'h0000_0003, 5'd20, 32'h0030_0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
